// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: 16-bit word count, then big-endian words.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module imem_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR
  } state_t;

  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic [15:0] idx_inc;

  assign accept   = rx_valid && rx_ready;
  assign len_full = {len_q[15:8], rx_data};
  assign idx_inc  = idx_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN_HI;
      LEN_HI:          if (accept) state_d = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          else if ({16'd0, len_full} > MAX_WORDS_U)
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA:  if (accept && byte_cnt_q == 2'd3) state_d = WRITE;
      WRITE: begin
        if (idx_inc == len_q)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        else
          state_d = DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (accept) state_d = (rx_data == chk_q) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  // The write address/data are latched as the 4th byte arrives so they are
  // stable during WRITE and simply hold afterwards.
  always_comb begin
    len_d       = len_q;
    idx_d       = idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          len_d      = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = '0;
`endif
        end
      end
      LEN_HI: if (accept) len_d[15:8] = rx_data;
      LEN_LO: if (accept) len_d[7:0]  = rx_data;
      DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ rx_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            mem_wdata_d = {word_q[23:0], rx_data};
          end
        end
      end
      WRITE:   idx_d = idx_inc;
      default: ;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    case (state_q)
      LEN_HI, LEN_LO, DATA: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are sent
// and popped by a monitor on each mem_we pulse.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned widx;
  logic [7:0]  xsum;

  always #5 clk = ~clk;

  imem_loader #(.MAX_WORDS(1024), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'd0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        $display("write addr=%h data=%h (expected %h/%h)", mem_addr, mem_wdata, e.addr, e.data);
        check("we_addr", mem_addr, e.addr);
        check("we_data", mem_wdata, e.data);
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    check({tag, "_mem_addr"}, mem_addr,          32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,        32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_error"},    {31'd0, error},    32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("rst_high");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_low");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    widx = 0;
    xsum = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    exp_q.push_back({BASE + 32'(widx * 4), w});
    widx++;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[31 - 8*i -: 8];
      xsum = xsum ^ b;
      send_byte(b, $urandom_range(0, max_gap));
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
  endtask

  task automatic send_checksum(input logic [7:0] flip);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xsum ^ flip, 0);
`else
    if (flip != 8'h00) $display("note: checksum disabled, byte not sent");
`endif
  endtask

  task automatic wait_end(input string tag, input logic exp_done, input logic exp_err);
    int n;
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"},     {31'd0, done},     {31'd0, exp_done});
    check({tag, "_error"},    {31'd0, error},    {31'd0, exp_err});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, ~exp_done});
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_pending"},  exp_q.size(),      32'd0);
    $display("session %s: done=%0b error=%0b", tag, done, error);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    widx = 0; xsum = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    // Two-word program
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    send_len(16'd2);
    send_word(32'h2408_0005, 0);
    send_word(32'h0000_0000, 0);
    send_checksum(8'h00);
    wait_end("two_words", 1'b1, 1'b0);
    check("addr_hold", mem_addr, BASE + 32'd4);
    check("data_hold", mem_wdata, 32'h0000_0000);
    repeat (3) @(negedge clk);
    check("done_persist", {31'd0, done}, 32'd1);

    // Over-capacity count
    pulse_start();
    check("restart_done_clr", {31'd0, done}, 32'd0);
    send_len(16'h0401);
    wait_end("too_long", 1'b0, 1'b1);
    pulse_start();
    check("restart_err_clr", {31'd0, error}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    do_reset();

    // Empty program
    pulse_start();
    send_len(16'd0);
    send_checksum(8'h00);
    wait_end("empty", 1'b1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_len(16'd0);
    send_checksum(8'h01);
    wait_end("empty_badchk", 1'b0, 1'b1);
`endif

    // Stalled/toggling rx_valid within a word
    pulse_start();
    send_len(16'd1);
    send_word(32'h8C01_0004, 3);
    send_checksum(8'h00);
    wait_end("stall", 1'b1, 1'b0);

    // Mid-word reset, then a clean session
    pulse_start();
    send_len(16'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset();
    pulse_start();
    send_len(16'd1);
    send_word(32'h1234_5678, 0);
    send_checksum(8'h00);
    wait_end("after_abort", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_len(16'd1);
    send_word(32'h0102_0304, 0);
    check("xsum_model", {24'd0, xsum}, 32'h04);
    send_checksum(8'h00);
    wait_end("chk_good", 1'b1, 1'b0);
    pulse_start();
    send_len(16'd1);
    send_word(32'h0102_0304, 0);
    send_checksum(8'h01);
    wait_end("chk_bad", 1'b0, 1'b1);
`endif

    // A start outside IDLE/DONE/ERR is ignored
    pulse_start();
    send_len(16'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'hCAFE_F00D, 0);
    send_checksum(8'h00);
    wait_end("start_ignored", 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024: instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h00000000: byte address written by the first loaded word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 rx_data  input  8  incoming program byte.
REQ-007 rx_valid  input  1  rx_data is valid.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  32  word-aligned byte address of the write; bits [1:0] always 0.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 busy  output  1  a load session is in progress.
REQ-013 done  output  1  the last load completed successfully.
REQ-014 error  output  1  the last load was aborted.
REQ-015 cpu_hold  output  1  CPU must stay stalled while high.

Function
REQ-016 A byte is transferred only in a cycle where rx_valid and rx_ready are both 1; rx_data is ignored in all other cycles.
REQ-017 States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE, ERR; rx_ready is 1 only in LEN_HI, LEN_LO, DATA and CHK.
REQ-018 In IDLE, DONE or ERR, start moves to LEN_HI and clears done and error; start is ignored in every other state.
REQ-019 Stream format: 16-bit word count N (high byte first), then N words; each word is sent most-significant byte first (big-endian).
REQ-020 After LEN_LO: N == 0 goes to CHK (macro defined) or DONE; N > MAX_WORDS goes to ERR; otherwise the FSM goes to DATA.
REQ-021 In DATA, after the 4th byte of a word is accepted, the FSM enters WRITE on the next cycle.
REQ-022 In WRITE, mem_we is 1 for exactly one cycle, with mem_addr = BASE_ADDR + 4*index and mem_wdata = the assembled word; index starts at 0.
REQ-023 After WRITE, index increments; if index equals N the FSM goes to CHK (macro defined) or DONE; otherwise it returns to DATA.
REQ-024 Address arithmetic is 32-bit and wraps modulo 2^32; the index register is 16 bits wide.
REQ-025 mem_we is 0 in every state except WRITE; mem_addr and mem_wdata hold their last values when mem_we is 0.
REQ-026 busy is 1 in LEN_HI, LEN_LO, DATA, WRITE and CHK.
REQ-027 done is 1 only in DONE and error is 1 only in ERR; both persist until the next start or rst.
REQ-028 cpu_hold is 0 only in DONE and 1 in every other state, including IDLE after reset and ERR.
REQ-029 A stalled input (rx_valid low) holds the FSM and any partial-word bytes indefinitely; there is no timeout.

Reset
REQ-030 rst, when asserted in any cycle including mid-session, returns the FSM to IDLE with index, byte counter and checksum cleared.
REQ-031 While rst is high and after it is released, the outputs are: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1.
REQ-032 Words already written before a mid-session reset are not rolled back.

Configuration
REQ-033 Macro IMEM_LOADER_CHECKSUM_EN, when defined, enables the following behaviour:
- after the last word (or directly after the count when N == 0), the FSM enters CHK and accepts one byte;
- that byte is compared with the XOR of all data bytes, excluding the count bytes;
- a match goes to DONE and a mismatch goes to ERR.
REQ-034 When IMEM_LOADER_CHECKSUM_EN is undefined, CHK and the checksum logic are absent and no trailing byte is consumed.

Verification
REQ-035 Reset, then start, then bytes 00 02 | 24 08 00 05 | 00 00 00 00 -> two mem_we pulses: addr 0x0 data 0x24080005, then addr 0x4 data 0x00000000; done=1 and cpu_hold=0.
REQ-036 Count 04 01 (1025) -> ERR; error=1, no mem_we pulse, cpu_hold=1; a following start clears error.
REQ-037 Count 00 00 -> DONE with no writes when the macro is undefined; with the macro defined, checksum byte 00 -> DONE and checksum byte 01 -> ERR.
REQ-038 rx_valid toggles randomly during one word 0x8C010004 -> a single write of 0x8C010004, with no bytes lost or duplicated.
REQ-039 rst asserted after 2 of 4 data bytes, then a new full session with N=1 and word 0x12345678 -> a write of 0x12345678 at BASE_ADDR, with no residue from the aborted bytes.
REQ-040 Macro defined, N=1, word 0x01020304, checksum byte 0x04 -> DONE; checksum byte 0x05 -> ERR.
